// File: rtl/operand_fetch_stage.sv
// ID/EX operand fetch stage: resolves RAW hazards by forwarding from EX and WB,
// inserts a one-cycle bubble on load-use, and registers operands plus
// write-back control for the execute stage.
module operand_fetch_stage #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [3:0]    id_opcode,
  input  logic [AW-1:0] id_op1,
  input  logic [AW-1:0] id_op2,
  input  logic          id_use1,
  input  logic          id_use2,
  input  logic          id_use15,
  input  logic [1:0]    id_rWrite,
  input  logic [AW-1:0] id_wop1,
  input  logic [AW-1:0] id_wop2,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  input  logic [DW-1:0] rf_r15,
  input  logic [1:0]    ex_rWrite,
  input  logic [AW-1:0] ex_wop1,
  input  logic [AW-1:0] ex_wop2,
  input  logic [DW-1:0] ex_wdata1,
  input  logic [DW-1:0] ex_wdata2,
  input  logic [DW-1:0] ex_r15data,
  input  logic          ex_is_load,
  input  logic [1:0]    wb_rWrite,
  input  logic [AW-1:0] wb_wop1,
  input  logic [AW-1:0] wb_wop2,
  input  logic [DW-1:0] wb_wdata1,
  input  logic [DW-1:0] wb_wdata2,
  input  logic [DW-1:0] wb_r15data,
  input  logic          flush,
  input  logic          hold,
  output logic          stall_out,
  output logic          out_valid,
  output logic [3:0]    out_opcode,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [DW-1:0] out_r15,
  output logic [1:0]    out_rWrite,
  output logic [AW-1:0] out_wop1,
  output logic [AW-1:0] out_wop2
);

  localparam logic [AW-1:0] R15 = AW'(15);

  typedef struct packed {
    logic          valid;
    logic [3:0]    opcode;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] r15;
    logic [1:0]    rw;
    logic [AW-1:0] wop1;
    logic [AW-1:0] wop2;
  } ex_slot_t;

  ex_slot_t slot_d, slot_q;

  // {hit, data} for one producing stage. Order mirrors last-write-wins in the
  // regfile: R15 (written after wop1) beats wop2 beats wop1.
  function automatic logic [DW:0] fwd_match(
    input logic [1:0]    rw,
    input logic [AW-1:0] wop1,
    input logic [AW-1:0] wop2,
    input logic [DW-1:0] wd1,
    input logic [DW-1:0] wd2,
    input logic [DW-1:0] r15d,
    input logic [AW-1:0] r
  );
    fwd_match = '0;
    if (rw == 2'b11 && r == R15)       fwd_match = {1'b1, r15d};
    else if (rw == 2'b10 && r == wop2) fwd_match = {1'b1, wd2};
    else if (rw != 2'b00 && r == wop1) fwd_match = {1'b1, wd1};
  endfunction

  // Younger producer (EX) wins over WB; regfile value is the fallback.
  function automatic logic [DW-1:0] pick(
    input logic          en,
    input logic [DW:0]   ex_m,
    input logic [DW:0]   wb_m,
    input logic [DW-1:0] rf
  );
    if (en && ex_m[DW])      pick = ex_m[DW-1:0];
    else if (en && wb_m[DW]) pick = wb_m[DW-1:0];
    else                     pick = rf;
  endfunction

  logic [DW:0]   ex_m1, ex_m2, ex_m15, wb_m1, wb_m2, wb_m15;
  logic [DW-1:0] opa, opb, op15;
  logic          lu;

  // Forwarding network and load-use detect
  always_comb begin
    ex_m1  = fwd_match(ex_rWrite, ex_wop1, ex_wop2, ex_wdata1, ex_wdata2, ex_r15data, id_op1);
    ex_m2  = fwd_match(ex_rWrite, ex_wop1, ex_wop2, ex_wdata1, ex_wdata2, ex_r15data, id_op2);
    ex_m15 = fwd_match(ex_rWrite, ex_wop1, ex_wop2, ex_wdata1, ex_wdata2, ex_r15data, R15);
    wb_m1  = fwd_match(wb_rWrite, wb_wop1, wb_wop2, wb_wdata1, wb_wdata2, wb_r15data, id_op1);
    wb_m2  = fwd_match(wb_rWrite, wb_wop1, wb_wop2, wb_wdata1, wb_wdata2, wb_r15data, id_op2);
    wb_m15 = fwd_match(wb_rWrite, wb_wop1, wb_wop2, wb_wdata1, wb_wdata2, wb_r15data, R15);
    opa    = pick(id_use1,  ex_m1,  wb_m1,  rf_data1);
    opb    = pick(id_use2,  ex_m2,  wb_m2,  rf_data2);
    op15   = pick(id_use15, ex_m15, wb_m15, rf_r15);
    // Only a load's wop1 result is late; its wop2/R15 results never stall.
    lu = id_valid && ex_is_load && (ex_rWrite != 2'b00) &&
         ((id_use1 && id_op1 == ex_wop1) ||
          (id_use2 && id_op2 == ex_wop1) ||
          (id_use15 && ex_wop1 == R15));
    // Gated by reset so upstream never sees a stall while the slot is cleared.
    stall_out = reset && (hold || lu) && !flush;
  end

  // Next-state of the EX slot: flush > hold > load-use bubble > normal load
  always_comb begin
    slot_d = slot_q;
    if (flush) begin
      slot_d = '0;
    end else if (hold) begin
      slot_d = slot_q;
    end else if (lu) begin
      slot_d.valid = 1'b0;
      slot_d.rw    = 2'b00;
    end else begin
      slot_d.valid  = id_valid;
      slot_d.rw     = id_valid ? id_rWrite : 2'b00;
      slot_d.opcode = id_opcode;
      slot_d.a      = opa;
      slot_d.b      = opb;
      slot_d.r15    = op15;
      slot_d.wop1   = id_wop1;
      slot_d.wop2   = id_wop2;
    end
  end

  // Slot register; the only state in the stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign out_valid  = slot_q.valid;
  assign out_opcode = slot_q.opcode;
  assign out_a      = slot_q.a;
  assign out_b      = slot_q.b;
  assign out_r15    = slot_q.r15;
  assign out_rWrite = slot_q.rw;
  assign out_wop1   = slot_q.wop1;
  assign out_wop2   = slot_q.wop2;

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- ID/EX pipeline stage sitting directly downstream of the register file.
- Takes decoded register specifiers and raw register-file read data, then resolves RAW hazards by forwarding from the EX and WB stages.
- Detects load-use hazards and inserts a bubble.
- Registers the resolved operands and write-back control for the execute stage.

Parameters:
- DW, 16, datapath width
- AW, 4, register specifier width (16 registers; R15 is implicit second-result register)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  decode stage holds a valid instruction
- id_opcode  in  4  decoded opcode, passed through
- id_op1, id_op2  in  AW  source specifiers (also drive regfile read ports)
- id_use1, id_use2, id_use15  in  1  instruction actually reads op1 / op2 / R15
- id_rWrite  in  2  write mode of this instruction (00 none, 01 wop1, 10 wop1+wop2, 11 wop1+R15)
- id_wop1, id_wop2  in  AW  destination specifiers
- rf_data1, rf_data2, rf_r15  in  DW  regfile read data for op1 / op2 / R15
- ex_rWrite  in  2  write mode of instruction currently in EX
- ex_wop1, ex_wop2  in  AW  EX destination specifiers
- ex_wdata1, ex_wdata2, ex_r15data  in  DW  EX results
- ex_is_load  in  1  EX instruction's wdata1 is not yet available (memory load)
- wb_rWrite, wb_wop1, wb_wop2, wb_wdata1, wb_wdata2, wb_r15data  in  as EX  instruction currently presented to regfile write port
- flush  in  1  squash instruction in this stage (taken branch)
- hold  in  1  downstream multi-cycle unit busy; freeze stage
- stall_out  out  1  to decode/fetch: do not advance
- out_valid  out  1  registered: EX slot valid
- out_opcode  out  4  registered opcode
- out_a, out_b, out_r15  out  DW  registered resolved operands
- out_rWrite  out  2  registered write mode (forced 00 on bubble)
- out_wop1, out_wop2  out  AW  registered destinations

Behaviour:
- Reset (reset=0, async): all registered outputs cleared to 0, including out_valid=0 and out_rWrite=2'b00. stall_out is combinational and evaluates to 0 while out_* are reset.
- Per-source forwarding match, evaluated for a stage S in {EX, WB} against specifier r. Highest first:
  - S_rWrite==11 && r==15 -> S_r15data
  - S_rWrite==10 && r==S_wop2 -> S_wdata2
  - S_rWrite!=00 && r==S_wop1 -> S_wdata1
  - This ordering matches last-write-wins in the regfile for duplicate destinations.
- Operand priority: EX match > WB match > rf_* value. R15 operand uses r=15 with rf_r15 as the fallback.
- Forwarding applies only when the corresponding id_use* is set; otherwise the rf value passes through unchanged.
- Load-use hazard, combinational:
  - lu = id_valid && ex_is_load && ex_rWrite!=00 && ((id_use1 && id_op1==ex_wop1) || (id_use2 && id_op2==ex_wop1) || (id_use15 && ex_wop1==15)).
  - A load's wdata2/r15data are never forwarded-pending; only wop1 is considered.
- stall_out = (hold || lu) && !flush.
- Register update on each rising edge, priority order:
  1. flush: out_valid<=0, out_rWrite<=00; other fields don't-care (hold 0).
  2. hold: all outputs keep their value.
  3. lu: bubble (out_valid<=0, out_rWrite<=00). Decode re-presents the same instruction next cycle and sees the load in WB, forwarded via WB.
  4. normal: out_valid<=id_valid; out_rWrite<=id_valid ? id_rWrite : 00; operands, opcode and destinations loaded.
- Latency: exactly 1 cycle from id_* to out_* when there is no stall.
- Maximum load-use penalty is 1 bubble.
- Invalid ID (id_valid=0) never raises lu or stall_out from lu.
- Reset asserted mid-stall: outputs clear immediately. After release the stage accepts the next id_* normally; no stall state persists (the design has no state beyond the output registers).
- Specifier 0 is a normal register (no hard-wired zero): forwarding to r==0 applies.

Test Plan:
- Reset, then id_op1=5, id_op2=2, rf_data1=0x0040, rf_data2=0x0050, no EX/WB writes -> next cycle out_a=0x0040, out_b=0x0050, out_valid=1.
- Dual forward: EX rWrite=01 wop1=5 wdata1=0x1234; WB rWrite=01 wop1=5 wdata1=0xBEEF; id_op1=5 -> out_a=0x1234. With EX rWrite=00 -> out_a=0xBEEF.
- Within-stage priority:
  - EX rWrite=10, wop1=wop2=3, wdata1=0x1111, wdata2=0x2222 -> op 3 gets 0x2222.
  - EX rWrite=11, wop1=15, r15data=0xAAAA, id_use15=1 -> out_r15=0xAAAA.
- Load-use: EX ex_is_load=1, rWrite=01, wop1=7; id_op2=7, id_use2=1 -> stall_out=1, next out_valid=0/out_rWrite=00. Following cycle WB wop1=7, wdata1=0x00FF -> out_b=0x00FF, out_valid=1.
- Flush during load-use and hold: flush=1, hold=1, lu=1 -> stall_out=0, next out_valid=0. hold=1 alone for 3 cycles -> out_* unchanged.
- Async reset asserted mid-hold, between clock edges -> out_valid and out_rWrite drop to 0 without waiting for a clock edge.
